// File: rtl/arg_formatter.sv
// Formats one labelled fixed-point argument as ASCII characters and hands them,
// one at a time, to a handshaked character writer.
module arg_formatter (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        trigger,
  input  logic [7:0]  arg_title,
  input  logic [15:0] value,
  input  logic [2:0]  precision,
  input  logic        last,
  input  logic        wr_rdy,
  input  logic        wr_done,
  input  logic        is_full,
  output logic        wr_trigger,
  output logic [7:0]  wr_char,
  output logic        rdy,
  output logic        done,
  output logic        invalid
);

  typedef enum logic [2:0] {
    IDLE, CONVERT, SELECT, WR_WAIT_RDY, WR_TRIGGER, WR_WAIT_DONE, DONE
  } state_t;

  typedef enum logic [2:0] {
    P_TITLE, P_SIGN, P_DIGIT, P_DOT, P_TERM, P_END
  } phase_t;

  state_t      state, state_next;
  phase_t      phase_r, sel_phase;
  logic [7:0]  title_r, sel_char;
  logic [2:0]  prec_r, dig_r, sel_dig, first_int;
  logic        last_r, neg_r;
  logic [15:0] bin_r, abs_value;
  logic [19:0] bcd_r, bcd_adj;
  logic [3:0]  cnt_r, cur_digit;
  logic        accept, bad_prec;

  assign accept    = (state == IDLE) && trigger && clk_en;
  assign bad_prec  = (precision > 3'd4);
  assign abs_value = value[15] ? (~value + 16'd1) : value;
  assign cur_digit = bcd_r[int'(dig_r) * 4 +: 4];

  // Double-dabble correction, applied to every BCD digit before each shift.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      bcd_adj[i*4 +: 4] = (bcd_r[i*4 +: 4] >= 4'd5) ? bcd_r[i*4 +: 4] + 4'd3
                                                     : bcd_r[i*4 +: 4];
    end
  end

  // Most significant integer digit to print: highest non-zero integer position,
  // falling back to the units position so at least one integer digit appears.
  always_comb begin
    first_int = prec_r;
    for (int i = 0; i < 5; i++) begin
      if (i >= int'(prec_r) && bcd_r[i*4 +: 4] != 4'd0) first_int = 3'(i);
    end
  end

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    sel_char  = 8'h00;
    sel_phase = phase_r;
    sel_dig   = dig_r;
    case (phase_r)
      P_TITLE: begin
        sel_char  = title_r;
        sel_phase = neg_r ? P_SIGN : P_DIGIT;
        sel_dig   = first_int;
      end
      P_SIGN: begin
        sel_char  = 8'h2D;
        sel_phase = P_DIGIT;
        sel_dig   = first_int;
      end
      P_DIGIT: begin
        sel_char = 8'h30 + {4'h0, cur_digit};
        if (dig_r == 3'd0) begin
          sel_phase = P_TERM;
        end else begin
          sel_dig = dig_r - 3'd1;
          if (dig_r == prec_r) sel_phase = P_DOT;
        end
      end
      P_DOT: begin
        sel_char  = 8'h2E;
        sel_phase = P_DIGIT;
      end
      P_TERM: begin
        sel_char  = last_r ? 8'h0A : 8'h20;
        sel_phase = P_END;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next = state;
    rdy        = 1'b0;
    done       = 1'b0;
    wr_trigger = 1'b0;
    case (state)
      IDLE: begin
        rdy  = 1'b1;
        done = !accept;
        if (trigger) state_next = bad_prec ? DONE : CONVERT;
      end
      CONVERT:      if (cnt_r == 4'd15) state_next = SELECT;
      SELECT:       state_next = (phase_r == P_END) ? DONE : WR_WAIT_RDY;
      WR_WAIT_RDY:  if (wr_rdy && !is_full) state_next = WR_TRIGGER;
      WR_TRIGGER: begin
        wr_trigger = 1'b1;
        if (!wr_rdy) state_next = WR_WAIT_DONE;
      end
      WR_WAIT_DONE: if (wr_done) state_next = (phase_r == P_END) ? DONE : SELECT;
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default:      state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset)       state <= IDLE;
    else if (clk_en) state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      title_r <= 8'h00;
      prec_r  <= 3'd0;
      last_r  <= 1'b0;
      neg_r   <= 1'b0;
      bin_r   <= 16'h0000;
      bcd_r   <= 20'h00000;
      cnt_r   <= 4'd0;
      phase_r <= P_TITLE;
      dig_r   <= 3'd0;
      wr_char <= 8'h00;
      invalid <= 1'b0;
    end else if (clk_en) begin
      case (state)
        IDLE: if (trigger) begin
          invalid <= bad_prec;
          if (!bad_prec) begin
            title_r <= arg_title;
            prec_r  <= precision;
            last_r  <= last;
            neg_r   <= value[15];
            bin_r   <= abs_value;
            bcd_r   <= 20'h00000;
            cnt_r   <= 4'd0;
            phase_r <= P_TITLE;
          end
        end
        CONVERT: begin
          {bcd_r, bin_r} <= {bcd_adj[18:0], bin_r, 1'b0};
          cnt_r          <= cnt_r + 4'd1;
        end
        SELECT: begin
          wr_char <= sel_char;
          phase_r <= sel_phase;
          dig_r   <= sel_dig;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arg_formatter.sv
// Directed bench for arg_formatter: a handshaking character-writer model
// captures the emitted stream, which is compared with hand-written strings.
module tb_arg_formatter;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en = 1'b1;
  logic        trigger;
  logic [7:0]  arg_title;
  logic [15:0] value;
  logic [2:0]  precision;
  logic        last;
  logic        wr_rdy = 1'b1;
  logic        wr_done = 1'b0;
  logic        is_full;
  logic        wr_trigger;
  logic [7:0]  wr_char;
  logic        rdy;
  logic        done;
  logic        invalid;

  int vectors = 0;
  int miscompares = 0;

  arg_formatter dut (
    .clk        (clk),
    .reset      (reset),
    .clk_en     (clk_en),
    .trigger    (trigger),
    .arg_title  (arg_title),
    .value      (value),
    .precision  (precision),
    .last       (last),
    .wr_rdy     (wr_rdy),
    .wr_done    (wr_done),
    .is_full    (is_full),
    .wr_trigger (wr_trigger),
    .wr_char    (wr_char),
    .rdy        (rdy),
    .done       (done),
    .invalid    (invalid)
  );

  always #5 clk = ~clk;

  // 0: clk_en always high, 1: toggles every cycle, 2: held low
  int en_mode = 0;
  always @(negedge clk) begin
    case (en_mode)
      0:       clk_en = 1'b1;
      1:       clk_en = ~clk_en;
      default: clk_en = 1'b0;
    endcase
  end

  logic last_en = 1'b0;
  always @(posedge clk) last_en = clk_en;

  // Character writer model: grabs wr_char on a new wr_trigger pulse, drops
  // wr_rdy, raises wr_done once the request is withdrawn, and releases after
  // an enabled edge has consumed wr_done.
  typedef enum {R_IDLE, R_TRIG, R_DONE} resp_t;
  resp_t       r_st = R_IDLE;
  byte unsigned stream[$];
  byte unsigned cap = 8'h00;
  int          pulses = 0;
  int          stab_err = 0;

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      r_st    = R_IDLE;
      wr_rdy  = 1'b1;
      wr_done = 1'b0;
    end else begin
      case (r_st)
        R_IDLE: if (wr_trigger === 1'b1) begin
          cap = wr_char;
          stream.push_back(wr_char);
          pulses++;
          wr_rdy = 1'b0;
          r_st   = R_TRIG;
        end
        R_TRIG: begin
          if (wr_char !== cap) stab_err++;
          if (wr_trigger === 1'b0) begin
            wr_done = 1'b1;
            r_st    = R_DONE;
          end
        end
        default: begin
          if (wr_char !== cap) stab_err++;
          if (last_en) begin
            wr_done = 1'b0;
            wr_rdy  = 1'b1;
            r_st    = R_IDLE;
          end
        end
      endcase
    end
  end

  task automatic wait_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one request, waits for completion and checks the captured stream.
  task automatic run_op(input string tag, input logic [7:0] t, input logic [15:0] v,
                        input logic [2:0] p, input logic l, input string exp,
                        input bit hold_full, output int lat, output int ncyc);
    int q0, p0, s0, cyc, n_got, mism;
    bit held;
    byte unsigned e;
    q0 = stream.size();
    p0 = pulses;
    s0 = stab_err;
    arg_title = t; value = v; precision = p; last = l; trigger = 1'b1;
    if (en_mode == 0) begin
      #1;
      chk({tag, ".done_drop"}, {31'd0, done}, 32'd0);
    end
    cyc = 0;
    while (rdy === 1'b1 && cyc < 100) begin
      wait_neg();
      cyc++;
    end
    // Scramble the inputs: the running operation must not notice.
    trigger = 1'b0; arg_title = 8'h00; value = 16'h7FFF; precision = 3'd2; last = ~l;
    chk({tag, ".accept"}, {31'd0, rdy}, 32'd0);
    chk({tag, ".invalid"}, {31'd0, invalid}, {31'd0, (p > 3'd4)});
    lat = -1;
    cyc = 0;
    held = 1'b0;
    while (done !== 1'b1 && cyc < 3000) begin
      if (wr_trigger === 1'b1 && lat < 0) lat = cyc;
      if (hold_full && !held && stream.size() - q0 == 1) begin
        is_full = 1'b1;
        p0 = pulses;
        repeat (20) wait_neg();
        chk({tag, ".full_hold"}, 32'(pulses), 32'(p0));
        is_full = 1'b0;
        held = 1'b1;
        cyc += 20;
        p0 = p0 - 1;
      end
      wait_neg();
      cyc++;
    end
    ncyc = cyc;
    chk({tag, ".done"}, {31'd0, done}, 32'd1);
    // A trigger presented in DONE must not start another operation.
    trigger = 1'b1;
    cyc = 0;
    while (rdy !== 1'b1 && cyc < 30) begin
      wait_neg();
      cyc++;
    end
    trigger = 1'b0;
    wait_neg();
    chk({tag, ".idle"}, {31'd0, rdy}, 32'd1);
    n_got = stream.size() - q0;
    mism = -1;
    for (int i = 0; i < exp.len(); i++) begin
      e = exp.getc(i);
      if (mism < 0 && (i >= n_got || stream[q0 + i] !== e)) mism = i;
    end
    chk({tag, ".len"}, 32'(n_got), 32'(exp.len()));
    chk({tag, ".first_bad_char"}, 32'(mism), 32'hFFFF_FFFF);
    chk({tag, ".stable"}, 32'(stab_err - s0), 32'd0);
    if (!hold_full) chk({tag, ".pulses"}, 32'(pulses - p0), 32'(exp.len()));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, ncyc, p0, cyc;
    reset = 1'b1; trigger = 1'b0; is_full = 1'b0;
    arg_title = 8'h00; value = 16'h0000; precision = 3'd0; last = 1'b0;
    repeat (3) wait_neg();
    chk("reset.rdy", {31'd0, rdy}, 32'd1);
    chk("reset.done", {31'd0, done}, 32'd1);
    chk("reset.wr_trigger", {31'd0, wr_trigger}, 32'd0);
    chk("reset.invalid", {31'd0, invalid}, 32'd0);
    chk("reset.wr_char", {24'd0, wr_char}, 32'h00);
    reset = 1'b0;
    wait_neg();

    run_op("x125", 8'h58, 16'd125, 3'd0, 1'b0, "X125 ", 1'b0, lat, ncyc);
    run_op("y_m12_5", 8'h59, -16'sd125, 3'd1, 1'b0, "Y-12.5 ", 1'b0, lat, ncyc);
    run_op("f0_005", 8'h46, 16'd5, 3'd3, 1'b1, "F0.005\n", 1'b0, lat, ncyc);
    run_op("x_min", 8'h58, 16'h8000, 3'd0, 1'b0, "X-32768 ", 1'b0, lat, ncyc);
    // accept edge -> 16 CONVERT -> SELECT -> WR_WAIT_RDY -> WR_TRIGGER
    chk("x_min.latency", 32'(lat), 32'd18);
    run_op("x0", 8'h58, 16'd0, 3'd0, 1'b0, "X0 ", 1'b0, lat, ncyc);
    run_op("full", 8'h59, -16'sd125, 3'd1, 1'b0, "Y-12.5 ", 1'b1, lat, ncyc);
    run_op("p4", 8'h50, 16'd1234, 3'd4, 1'b1, "P0.1234\n", 1'b0, lat, ncyc);

    en_mode = 1;
    run_op("en_f", 8'h46, 16'd5, 3'd3, 1'b1, "F0.005\n", 1'b0, lat, ncyc);
    run_op("en_min", 8'h58, 16'h8000, 3'd0, 1'b0, "X-32768 ", 1'b0, lat, ncyc);

    // With clk_en held low a trigger must not leave IDLE.
    en_mode = 2;
    wait_neg();
    trigger = 1'b1;
    repeat (5) wait_neg();
    chk("en_hold.rdy", {31'd0, rdy}, 32'd1);
    trigger = 1'b0;
    en_mode = 0;
    wait_neg();

    run_op("inv", 8'h58, 16'd100, 3'd6, 1'b0, "", 1'b0, lat, ncyc);
    chk("inv.flag", {31'd0, invalid}, 32'd1);
    chk("inv.fast", {31'd0, (ncyc <= 1)}, 32'd1);
    run_op("after_inv", 8'h58, 16'd125, 3'd0, 1'b0, "X125 ", 1'b0, lat, ncyc);
    chk("after_inv.flag", {31'd0, invalid}, 32'd0);

    // Reset while a write request is outstanding.
    arg_title = 8'h58; value = 16'd125; precision = 3'd0; last = 1'b0; trigger = 1'b1;
    cyc = 0;
    while (rdy === 1'b1 && cyc < 100) begin wait_neg(); cyc++; end
    trigger = 1'b0;
    cyc = 0;
    while (wr_trigger !== 1'b1 && cyc < 100) begin wait_neg(); cyc++; end
    chk("mid.reached_wr_trigger", {31'd0, wr_trigger}, 32'd1);
    reset = 1'b1;
    wait_neg();
    chk("mid.wr_trigger", {31'd0, wr_trigger}, 32'd0);
    chk("mid.rdy", {31'd0, rdy}, 32'd1);
    chk("mid.done", {31'd0, done}, 32'd1);
    chk("mid.wr_char", {24'd0, wr_char}, 32'h00);
    wait_neg();
    reset = 1'b0;
    p0 = pulses;
    repeat (10) wait_neg();
    chk("mid.no_pulse", 32'(pulses), 32'(p0));
    run_op("post_reset", 8'h59, -16'sd125, 3'd1, 1'b0, "Y-12.5 ", 1'b0, lat, ncyc);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
